// File: rtl/instruction_fetch_ctrl.sv
// rtl/instruction_fetch_ctrl.sv - single-outstanding instruction fetch controller
//
// Purpose: issues word-aligned reads to instruction memory, holds each returned
// word for the decoder until accepted, and follows branch/jump/trap redirects.
// A redirect never withdraws a request already on the bus; the late response is
// drained and discarded before fetching from the newest redirect target.
//
// Ports:
//   clk_in           clock, all state changes on the rising edge
//   rst_n_in         asynchronous active-low reset
//   imem_req_out     read request (FETCH and DRAIN only)
//   imem_addr_out    read address, bits [1:0] always 0
//   imem_ack_in      memory response strobe, imem_rdata_in valid with it
//   imem_rdata_in    returned instruction word
//   instr_valid_out  instr_out/pc_out hold an instruction for the decoder
//   instr_ready_in   decoder accepts the held instruction
//   instr_out        held instruction word
//   pc_out           address of the held instruction
//   redirect_in      redirect request
//   redirect_pc_in   redirect target, bits [1:0] ignored

module instruction_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in
);

  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] redirect_tgt;
  logic [31:0] latest_tgt;
  logic [31:0] hold_tgt;

  // Redirect target with the byte offset dropped.
  assign redirect_tgt = redirect_pc_in & ALIGN_MASK;

  // Target when leaving IDLE or DRAIN: a redirect in this very cycle wins over
  // whatever target was recorded earlier.
  assign latest_tgt = redirect_in ? redirect_tgt : fetch_pc_q;

  // Leaving HOLD: redirect squashes the held word, otherwise sequential fetch.
  // The +4 wraps naturally at 2^32.
  assign hold_tgt = redirect_in ? redirect_tgt : (pc_q + 32'd4);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC_ALIGNED;
      addr_q     <= RESET_PC_ALIGNED;
      instr_q    <= 32'd0;
      pc_q       <= 32'd0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= FETCH;
          fetch_pc_q <= latest_tgt;
          addr_q     <= latest_tgt;
          req_q      <= 1'b1;
          valid_q    <= 1'b0;
        end

        FETCH: begin
          if (imem_ack_in) begin
            if (redirect_in) begin
              // Response arrived for a now-stale address: drop it and
              // re-request straight away at the redirect target.
              fetch_pc_q <= redirect_tgt;
              addr_q     <= redirect_tgt;
            end else begin
              instr_q <= imem_rdata_in;
              pc_q    <= fetch_pc_q;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
              state_q <= HOLD;
            end
          end else if (redirect_in) begin
            // Keep the bus request and its address untouched; only the
            // target for the next fetch changes.
            fetch_pc_q <= redirect_tgt;
            state_q    <= DRAIN;
          end
        end

        DRAIN: begin
          if (imem_ack_in) begin
            fetch_pc_q <= latest_tgt;
            addr_q     <= latest_tgt;
            state_q    <= FETCH;
          end else if (redirect_in) begin
            fetch_pc_q <= redirect_tgt;
          end
        end

        HOLD: begin
          if (redirect_in || instr_ready_in) begin
            fetch_pc_q <= hold_tgt;
            addr_q     <= hold_tgt;
            req_q      <= 1'b1;
            valid_q    <= 1'b0;
            state_q    <= FETCH;
          end
        end

        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_out    = req_q;
  assign imem_addr_out   = addr_q;
  assign instr_valid_out = valid_q;
  assign instr_out       = instr_q;
  assign pc_out          = pc_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// tb/tb_instruction_fetch_ctrl.sv - self-checking bench for instruction_fetch_ctrl

module tb_instruction_fetch_ctrl;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0002;

  logic        clk_in;
  logic        rst_n_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;

  instruction_fetch_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_ack_in     (imem_ack_in),
    .imem_rdata_in   (imem_rdata_in),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec;
  int n_err;
  int n_delivered;

  // Reference model: a request is either outstanding (possibly stale) or an
  // instruction is being held, or the controller is in its post-reset pause.
  bit          m_starting;
  bit          m_busy;
  bit          m_stale;
  bit          m_held;
  logic [31:0] m_req_addr;
  logic [31:0] m_target;
  logic [31:0] m_instr;
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_starting = 1'b1;
    m_busy     = 1'b0;
    m_stale    = 1'b0;
    m_held     = 1'b0;
    m_req_addr = TB_RESET_PC & 32'hFFFF_FFFC;
    m_target   = TB_RESET_PC & 32'hFFFF_FFFC;
    m_instr    = 32'd0;
    m_pc       = 32'd0;
  endtask

  task automatic m_issue(input logic [31:0] a);
    m_busy     = 1'b1;
    m_stale    = 1'b0;
    m_req_addr = a;
  endtask

  task automatic m_step(input logic ack, input logic [31:0] rd, input logic redir,
                        input logic [31:0] rp, input logic rdy);
    logic [31:0] tgt;
    tgt = rp & 32'hFFFF_FFFC;
    if (m_starting) begin
      m_starting = 1'b0;
      m_issue(redir ? tgt : m_target);
    end else if (m_busy) begin
      if (ack) begin
        if (redir) m_issue(tgt);
        else if (m_stale) m_issue(m_target);
        else begin
          m_busy  = 1'b0;
          m_held  = 1'b1;
          m_instr = rd;
          m_pc    = m_req_addr;
          n_delivered++;
        end
      end else if (redir) begin
        m_stale  = 1'b1;
        m_target = tgt;
      end
    end else if (m_held) begin
      if (redir) begin
        m_held = 1'b0;
        m_issue(tgt);
      end else if (rdy) begin
        m_held = 1'b0;
        m_issue(m_pc + 32'd4);
      end
    end
  endtask

  task automatic check_outputs();
    chk("req", {31'd0, imem_req_out}, {31'd0, m_busy});
    chk("valid", {31'd0, instr_valid_out}, {31'd0, m_held});
    if (m_busy) chk("addr", imem_addr_out, m_req_addr);
    if (m_held) begin
      chk("instr", instr_out, m_instr);
      chk("pc", pc_out, m_pc);
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs compared at the next one.
  task automatic cyc(input logic ack, input logic [31:0] rd, input logic redir,
                     input logic [31:0] rp, input logic rdy);
    imem_ack_in    = ack;
    imem_rdata_in  = rd;
    redirect_in    = redir;
    redirect_pc_in = rp;
    instr_ready_in = rdy;
    m_step(ack, rd, redir, rp, rdy);
    @(posedge clk_in);
    @(negedge clk_in);
    check_outputs();
  endtask

  initial begin
    int lat;
    int wcnt;
    bit was_busy;
    logic a;
    logic r;
    n_vec = 0;
    n_err = 0;
    n_delivered = 0;
    rst_n_in = 1'b0;
    imem_ack_in = 1'b0;
    imem_rdata_in = 32'd0;
    instr_ready_in = 1'b0;
    redirect_in = 1'b0;
    redirect_pc_in = 32'd0;
    m_reset();

    // Reset values.
    repeat (2) @(negedge clk_in);
    chk("rst_req", {31'd0, imem_req_out}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_out}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_addr", imem_addr_out, 32'h0000_0000);
    rst_n_in = 1'b1;

    // Single-cycle memory, ready always: sequential stream 0x0, 0x4, 0x8.
    cyc(0, 0, 0, 0, 1);
    chk("first_addr", imem_addr_out, 32'h0000_0000);
    for (int i = 0; i < 6; i++) cyc(m_busy, 32'h1000_0000 + i, 0, 0, 1);
    chk("seq_count", n_delivered, 3);
    chk("seq_addr", imem_addr_out, 32'h0000_000C);

    // Redirect to 0x10, then stall the decoder for five cycles.
    cyc(1, 32'hAAAA_0000, 1, 32'h0000_0010, 0);
    cyc(1, 32'hCAFE_0010, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("after_stall_addr", imem_addr_out, 32'h0000_0014);

    // Redirect to 0x103 while the request is outstanding; late ack dropped.
    cyc(0, 0, 1, 32'h0000_0103, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 1);
    chk("drain_addr", imem_addr_out, 32'h0000_0100);
    chk("drain_valid", {31'd0, instr_valid_out}, 32'd0);

    // Ack coincident with redirect: data dropped, refetch at 0x200.
    cyc(1, 32'h1234_5678, 1, 32'h0000_0200, 1);
    chk("ack_redir_addr", imem_addr_out, 32'h0000_0200);

    // Wraparound from 0xFFFF_FFFC.
    cyc(1, 32'h5555_0000, 0, 0, 0);
    cyc(0, 0, 1, 32'hFFFF_FFFF, 0);
    cyc(1, 32'h7777_7777, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_addr", imem_addr_out, 32'h0000_0000);

    // Randomized traffic with variable memory latency and stray acks.
    lat = 0;
    wcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      was_busy = m_busy;
      a = m_busy ? (wcnt >= lat) : ($urandom_range(9) == 0);
      r = ($urandom_range(7) == 0);
      cyc(a, $urandom, r, $urandom, ($urandom_range(2) != 0));
      if (was_busy && !a) wcnt++;
      else begin
        wcnt = 0;
        lat = $urandom_range(3);
      end
    end

    // Async reset in the middle of a drain: request drops without a clock edge.
    while (m_held || m_starting) cyc(0, 0, 1, 32'h0000_0300, 0);
    if (!m_busy) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0400, 0);
    chk("drain_req", {31'd0, imem_req_out}, 32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_req_out}, 32'd0);
    chk("mid_rst_addr", imem_addr_out, 32'h0000_0000);
    chk("mid_rst_valid", {31'd0, instr_valid_out}, 32'd0);
    m_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    cyc(0, 0, 0, 0, 1);
    chk("restart_addr", imem_addr_out, 32'h0000_0000);
    for (int i = 0; i < 6; i++) cyc(m_busy, 32'h2000_0000 + i, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
